// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and the alignment rule for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RDATA = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  // Size 2'b11 is never legal, so it is reported as a fault.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = lane[0];
      SIZE_WORD: misaligned = |lane;
      default:   misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response bus and DataMem single-port bus of the load/store unit.
// Handshake: a request transfers on a posedge where req_valid && req_ready; resp_valid is a
// one-cycle pulse with no backpressure, and the requester holds req_valid until accepted.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misalign;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign
  );
endinterface

interface dmem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  modport master (output mem_a, mem_wd, mem_we, input mem_rd);
  modport slave  (input mem_a, mem_wd, mem_we, output mem_rd);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling: sub-word load extraction/extension and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data = is_unsigned ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged    = word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data = is_unsigned ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged    = word;
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: one request at a time, alignment check, and sequencing
// of DataMem's single port including read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_if.slave       req,
  dmem_if.master     mem,
  output lsu_state_t state
);

  lsu_state_t        state_q, state_d;
  logic              lat_we;
  logic              lat_unsigned;
  logic              lat_fault;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] merged_word;

  lsu_align u_align (
    .word        (mem.mem_rd),
    .wdata       (lat_wdata),
    .lane        (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .load_data   (load_word),
    .merged      (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Word stores need no old data, so they skip the read cycles entirely.
  always_comb begin
    state_d           = state_q;
    req.req_ready     = 1'b0;
    req.resp_valid    = 1'b0;
    req.resp_misalign = 1'b0;
    mem.mem_we        = 1'b0;
    mem.mem_wd        = '0;
    case (state_q)
      ST_IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          if (misaligned(req.req_size, req.req_addr[1:0]))
            state_d = ST_RESP;
          else if (req.req_we && req.req_size == SIZE_WORD)
            state_d = ST_WRITE;
          else
            state_d = ST_READ;
        end
      end
      ST_READ:  state_d = ST_RDATA;
      ST_RDATA: state_d = lat_we ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        mem.mem_we = 1'b1;
        mem.mem_wd = wr_word;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        req.resp_valid    = 1'b1;
        req.resp_misalign = lat_fault;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_fault    <= 1'b0;
      lat_size     <= 2'b00;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      wr_word      <= '0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req.req_valid) begin
            lat_we       <= req.req_we;
            lat_unsigned <= req.req_unsigned;
            lat_fault    <= misaligned(req.req_size, req.req_addr[1:0]);
            lat_size     <= req.req_size;
            lat_addr     <= req.req_addr;
            lat_wdata    <= req.req_wdata;
            wr_word      <= req.req_wdata;
            rdata_q      <= '0;
          end
        end
        ST_RDATA: begin
          if (lat_we) wr_word <= merged_word;
          else        rdata_q <= load_word;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_a      = {2'b00, lat_addr[ADDR_W-1:2]};
  assign req.resp_rdata = rdata_q;
  assign state          = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small synchronous-read DataMem model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  lsu_state_t dbg_state;

  lsu_if  #(.ADDR_W(32), .DATA_W(32)) req_bus ();
  dmem_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req_bus),
    .mem   (mem_bus),
    .state (dbg_state)
  );

  always #5 clk = ~clk;

  // DataMem model: 16 words, index wraps on the low four bits, read-before-write.
  logic [31:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_val = 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_bus.mem_we) mem[mem_bus.mem_a[3:0]] <= mem_bus.mem_wd;
    mem_bus.mem_rd <= mem[mem_bus.mem_a[3:0]];
  end

  int tests  = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic set_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_bus.req_we       = we;
    req_bus.req_size     = size;
    req_bus.req_unsigned = uns;
    req_bus.req_addr     = addr;
    req_bus.req_wdata    = wdata;
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic mis,
                         output int we_cnt, output logic [31:0] ra,
                         output logic [31:0] wa, output logic [31:0] wd);
    lat = 0; rdata = 32'h0; mis = 1'b0; we_cnt = 0; ra = 32'h0; wa = 32'h0; wd = 32'h0;
    @(negedge clk);
    check("ready_before_req", {31'h0, req_bus.req_ready}, 32'h1);
    set_req(we, size, uns, addr, wdata);
    req_bus.req_valid = 1'b1;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) ra = mem_bus.mem_a;
      if (mem_bus.mem_we) begin
        we_cnt++;
        wa = mem_bus.mem_a;
        wd = mem_bus.mem_wd;
      end
      if (req_bus.resp_valid) begin
        lat   = c;
        rdata = req_bus.resp_rdata;
        mis   = req_bus.resp_misalign;
      end
    end
    if (lat == 0) check("resp_timeout", 32'h0, 32'h1);
  endtask

  int          lat, we_cnt, resp_n, acc_n, extra, rst_resp, rst_we;
  logic [31:0] rdata, ra, wa, wd, got_rd;
  logic        mis, acc;

  localparam logic [31:0] B2B_ADDR [3] = '{32'h14, 32'h16, 32'h18};
  localparam logic [1:0]  B2B_SIZE [3] = '{SIZE_WORD, SIZE_HALF, SIZE_BYTE};
  localparam logic        B2B_UNS  [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    req_bus.req_valid = 1'b0;
    set_req(1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0);
    #3;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_ready", {31'h0, req_bus.req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, req_bus.resp_valid}, 32'h0);
    check("rst_rdata", req_bus.resp_rdata, 32'h0);
    check("rst_misalign", {31'h0, req_bus.resp_misalign}, 32'h0);
    check("rst_mem_a", mem_bus.mem_a, 32'h0);
    check("rst_mem_wd", mem_bus.mem_wd, 32'h0);
    check("rst_mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Word store
    run_req(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_we_cnt", 32'(we_cnt), 32'd1);
    check("sw_mem_a", wa, 32'h4);
    check("sw_mem_wd", wd, 32'hDEADBEEF);
    check("sw_mis", {31'h0, mis}, 32'h0);
    check("sw_rdata", rdata, 32'h0);
    @(negedge clk);
    check("sw_mem4", mem[4], 32'hDEADBEEF);

    // Sub-word loads from 0x80FF7F01
    preload(4'd4, 32'h80FF7F01);
    run_req(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_we_cnt", 32'(we_cnt), 32'd0);
    check("lb_read_a", ra, 32'h4);
    run_req(1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("lbu_rdata", rdata, 32'h00000080);
    run_req(1'b0, SIZE_BYTE, 1'b0, 32'h11, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("lb1_rdata", rdata, 32'h0000007F);
    run_req(1'b0, SIZE_HALF, 1'b0, 32'h12, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("lh_rdata", rdata, 32'hFFFF80FF);
    run_req(1'b0, SIZE_HALF, 1'b1, 32'h10, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("lhu_rdata", rdata, 32'h00007F01);

    // Sub-word stores (read-modify-write)
    preload(4'd4, 32'h11223344);
    run_req(1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h0000ABCD, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("sh_lat", 32'(lat), 32'd4);
    check("sh_we_cnt", 32'(we_cnt), 32'd1);
    check("sh_mem_a", wa, 32'h4);
    check("sh_mem_wd", wd, 32'hABCD3344);
    check("sh_rdata", rdata, 32'h0);
    run_req(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h123456EE, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("sb_lat", 32'(lat), 32'd4);
    check("sb_mem_wd", wd, 32'hABCDEE44);
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("lw_after_rmw", rdata, 32'hABCDEE44);

    // Faults
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h06, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("mis_w_lat", 32'(lat), 32'd1);
    check("mis_w_flag", {31'h0, mis}, 32'h1);
    check("mis_w_rdata", rdata, 32'h0);
    check("mis_w_we", 32'(we_cnt), 32'd0);
    run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("mis_sz_lat", 32'(lat), 32'd1);
    check("mis_sz_flag", {31'h0, mis}, 32'h1);
    check("mis_sz_we", 32'(we_cnt), 32'd0);
    run_req(1'b1, SIZE_HALF, 1'b0, 32'h13, 32'h1234, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("mis_h_flag", {31'h0, mis}, 32'h1);
    check("mis_h_we", 32'(we_cnt), 32'd0);
    @(negedge clk);
    check("mis_mem4", mem[4], 32'hABCDEE44);

    // Top of address space maps straight through
    preload(4'd15, 32'hCAFEF00D);
    run_req(1'b0, SIZE_WORD, 1'b0, 32'hFFFFFFFC, 32'h0, lat, rdata, mis, we_cnt, ra, wa, wd);
    check("wrap_read_a", ra, 32'h3FFFFFFF);
    check("wrap_rdata", rdata, 32'hCAFEF00D);

    // Back-to-back with req_valid held
    preload(4'd5, 32'h01234567);
    preload(4'd6, 32'h89ABCDEF);
    exp_q.push_back(32'h01234567);
    exp_q.push_back(32'h00000123);
    exp_q.push_back(32'hFFFFFFEF);
    resp_n = 0; acc_n = 0;
    @(negedge clk);
    set_req(1'b0, B2B_SIZE[0], B2B_UNS[0], B2B_ADDR[0], 32'h0);
    req_bus.req_valid = 1'b1;
    for (int c = 0; c < 40 && resp_n < 3; c++) begin
      if (req_bus.resp_valid) begin
        got_rd = req_bus.resp_rdata;
        resp_n++;
        if (exp_q.size() == 0) check("b2b_extra_resp", 32'h1, 32'h0);
        else check("b2b_rdata", got_rd, exp_q.pop_front());
      end
      acc = req_bus.req_ready && req_bus.req_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_n++;
        if (acc_n < 3) set_req(1'b0, B2B_SIZE[acc_n], B2B_UNS[acc_n], B2B_ADDR[acc_n], 32'h0);
        else req_bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_bus.resp_valid) extra++;
    end
    check("b2b_resp_count", 32'(resp_n), 32'd3);
    check("b2b_accept_count", 32'(acc_n), 32'd3);
    check("b2b_extra", 32'(extra), 32'd0);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset during RDATA of a byte store
    preload(4'd8, 32'h55667788);
    @(negedge clk);
    set_req(1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h000000AA);
    req_bus.req_valid = 1'b1;
    rst_we = 0; rst_resp = 0;
    @(posedge clk);
    #1 req_bus.req_valid = 1'b0;
    if (mem_bus.mem_we) rst_we++;
    @(posedge clk);
    #2;
    check("rdata_state", 32'(dbg_state), 32'(ST_RDATA));
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("async_rst_we", {31'h0, mem_bus.mem_we}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_bus.mem_we) rst_we++;
      if (req_bus.resp_valid) rst_resp++;
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_bus.mem_we) rst_we++;
      if (req_bus.resp_valid) rst_resp++;
    end
    check("rst_abort_we", 32'(rst_we), 32'd0);
    check("rst_abort_resp", 32'(rst_resp), 32'd0);
    check("rst_abort_mem8", mem[8], 32'h55667788);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
